adiv5_mem_ap_seq: RTL and testbench
===================================

# adiv5_mem_ap_seq

Sequencer that turns single memory read/write requests into ADIv5 MEM-AP command sequences for the `swd_adiv5` command/response FIFO interface. It caches DP SELECT, CSW and TAR, so only registers whose value changes are rewritten. It issues the DP RDBUFF read that completes posted AP reads. It sits between the bridge's memory-request front end and `swd_adiv5`, and is the only writer of its command FIFO.

## Interface
Parameters:
- CSW_BASE, 32'h2300_0000: CSW value with bits [2:0] replaced by REQ_SIZE; AddrInc is always off.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- AP_SEL  in  8  MEM-AP index; must be stable while busy; a change invalidates the SELECT cache
- FLUSH  in  1  pulse that invalidates all caches; taken in IDLE, or at the end of the current request if busy
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  high only in IDLE
- REQ_WRITE  in  1  1 = write
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word
- REQ_ADDR  in  32  byte address
- REQ_WDATA  in  32  lane-aligned write data, passed through unchanged
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  32  raw RDBUFF word for reads, 0 for writes
- RSP_ERR  out  1  sequence aborted on a non-OK status
- CMD_WRDATA  out  36  {DATA[31:0], ADDR[1:0], APnDP, RnW}
- CMD_WREN  out  1  push strobe
- CMD_WRFULL  in  1  command FIFO full
- ADI_RDDATA  in  35  {DATA[31:0], STAT[2:0]}
- ADI_RDEN  out  1  pop strobe
- ADI_RDEMPTY  in  1  response FIFO empty

## Operation
- Reset values: state IDLE, all cache-valid flags 0, REQ_READY 1, RSP_VALID 0, RSP_RDATA 0, RSP_ERR 0, CMD_WREN 0, ADI_RDEN 0.
- States: IDLE, SEL, CSW, TAR, DRW, RDBUF, WAIT, DONE.
- On REQ_VALID in IDLE, latch the request. The first needed step, in order SEL, CSW, TAR, DRW, is entered:
  - SEL is needed if !sel_ok or AP_SEL != cached value.
  - CSW is needed if !csw_ok or REQ_SIZE != cached size.
  - TAR is needed if !tar_ok or REQ_ADDR != cached TAR.
- Command encodings (low nibble = {ADDR, APnDP, RnW}):
  - SELECT: data {AP_SEL, 24'h0}, nibble 4'b1000.
  - CSW: data CSW_BASE with bits [2:0] = size, nibble 4'b0010.
  - TAR: nibble 4'b0110.
  - DRW: write 4'b1110 with REQ_WDATA; read 4'b1111 with data 0.
  - RDBUFF: 4'b1101 with data 0.
- Each command state asserts CMD_WREN for exactly one cycle, when CMD_WRFULL is low, then moves to WAIT.
- WAIT pops one response when ADI_RDEMPTY is low. Data is sampled the cycle after ADI_RDEN. There is exactly one outstanding command.
- STAT == 3'b100: update the corresponding cache value and set its valid flag, then advance to the next needed step.
  - After a DRW read, the next step is RDBUF. After RDBUF, or after a DRW write, go to DONE.
- Any other STAT: clear all three valid flags, set RSP_ERR, go to DONE with no further commands.
- DONE: pulse RSP_VALID for one cycle; RSP_RDATA = RDBUFF data for reads, else 0; then IDLE.
- A pending FLUSH clears all valid flags on the DONE→IDLE transition. FLUSH arriving in the same cycle a request is accepted takes effect before the cache compare.
- TAR is never auto-incremented; the cached TAR always equals the last written value.
- Reset mid-sequence: immediate return to reset values. `swd_adiv5` shares this reset, so no stale responses remain.

## Timing
- REQ_READY is combinational from state.
- Per command, with the FIFOs not full/empty: 1 push cycle + PHY latency + 1 pop cycle + 1 capture cycle.
- Fully cached write: exactly 1 command.
- Fully cached read: exactly 2 commands.
- Cold read: 5 commands (SELECT, CSW, TAR, DRW, RDBUFF).
- RSP_VALID asserts 1 cycle after the final capture.
- CMD_WREN and ADI_RDEN are never high in the same cycle.

## Structure
- Package `adiv5_pkg`:
  - command/response width constants;
  - STAT_OK = 3'b100, STAT_FAULT = 3'b001;
  - 4-bit register selectors DP_SELECT, DP_RDBUFF, AP_CSW, AP_TAR, AP_DRW;
  - the state enum.
- No sub-module; a single flat FSM with the cache registers.

## Test plan
- Cold word write 0x2000_0000 ← 0xDEAD_BEEF, AP_SEL=0 → 4 commands (SELECT, CSW 0x2300_0002, TAR, DRW); RSP_VALID with RSP_ERR=0. Repeating the same write → 1 DRW command only.
- Read 0x2000_0000 with the caches warm; model returns 0 for DRW and 0x1234_5678 for RDBUFF → RSP_RDATA=0x1234_5678.
- Byte write to the same address → CSW 0x2300_0000 rewritten, TAR skipped. AP_SEL changed to 1 → SELECT {8'h01, 24'h0} reissued.
- STAT=3'b001 on the TAR write → no DRW, RSP_ERR=1. The next identical request reissues SELECT, CSW and TAR.
- CMD_WRFULL held high for 20 cycles → CMD_WREN stays 0; the command is pushed on the first cycle it drops. FLUSH mid-request → the following request is cold.
- RESET asserted while in WAIT → REQ_READY=1 immediately and all outputs at reset values; the next request is a cold sequence.

Source files
------------

// File: rtl/adiv5_pkg.sv
// ---------------------------------------------------------------------------
// adiv5_pkg
// Shared constants for the ADIv5 MEM-AP request sequencer:
//   - command / response word widths for the swd_adiv5 FIFO interface
//   - SWD ACK status codes as returned in the response STAT field
//   - 4-bit register selectors {ADDR[1:0], APnDP, RnW=0}; OR in RnW for reads
//   - sequencer state enum and the "first needed step" helper
// ---------------------------------------------------------------------------
package adiv5_pkg;

  localparam int CMD_W  = 36;  // {DATA[31:0], ADDR[1:0], APnDP, RnW}
  localparam int RSP_W  = 35;  // {DATA[31:0], STAT[2:0]}
  localparam int DATA_W = 32;

  localparam logic [2:0] STAT_OK    = 3'b100;
  localparam logic [2:0] STAT_FAULT = 3'b001;

  // Selectors carry RnW = 0; read commands set bit 0.
  localparam logic [3:0] DP_SELECT = 4'b1000;
  localparam logic [3:0] DP_RDBUFF = 4'b1100;
  localparam logic [3:0] AP_CSW    = 4'b0010;
  localparam logic [3:0] AP_TAR    = 4'b0110;
  localparam logic [3:0] AP_DRW    = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_CSW   = 3'd2,
    ST_TAR   = 3'd3,
    ST_DRW   = 3'd4,
    ST_RDBUF = 3'd5,
    ST_WAIT  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Steps are always taken in SEL, CSW, TAR, DRW order; DRW is never skipped.
  function automatic state_e first_step(input logic need_sel,
                                        input logic need_csw,
                                        input logic need_tar);
    if (need_sel)      return ST_SEL;
    else if (need_csw) return ST_CSW;
    else if (need_tar) return ST_TAR;
    else               return ST_DRW;
  endfunction

endpackage

// File: rtl/adiv5_mem_ap_seq.sv
// ---------------------------------------------------------------------------
// adiv5_mem_ap_seq
// Turns single memory read/write requests into ADIv5 MEM-AP command
// sequences for swd_adiv5. DP SELECT, CSW size and TAR are cached so only
// changed registers are rewritten. AP reads are posted, so a read is
// completed with a DP RDBUFF read. Exactly one command is outstanding.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   AP_SEL[7:0]           MEM-AP index (stable while busy)
//   FLUSH                 invalidate all caches (deferred to end if busy)
//   REQ_*                 request handshake / payload (READY only in IDLE)
//   RSP_VALID/RDATA/ERR   one-cycle completion pulse, read data, abort flag
//   CMD_WRDATA/WREN/WRFULL  command FIFO push side
//   ADI_RDDATA/RDEN/RDEMPTY response FIFO pop side (data valid the cycle
//                         after RDEN)
// ---------------------------------------------------------------------------
module adiv5_mem_ap_seq
  import adiv5_pkg::*;
#(
  parameter logic [31:0] CSW_BASE = 32'h2300_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        AP_SEL,
  input  logic              FLUSH,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [1:0]        REQ_SIZE,
  input  logic [31:0]       REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic [CMD_W-1:0]  CMD_WRDATA,
  output logic              CMD_WREN,
  input  logic              CMD_WRFULL,
  input  logic [RSP_W-1:0]  ADI_RDDATA,
  output logic              ADI_RDEN,
  input  logic              ADI_RDEMPTY
);

  // Sequencer state
  state_e      r_state;
  state_e      r_cur;        // command state whose response WAIT is collecting
  logic        r_popped;     // response popped; data is captured next cycle
  logic        r_flush_pend;

  // Latched request
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_ap;
  logic        r_need_sel;
  logic        r_need_csw;
  logic        r_need_tar;

  // Register caches
  logic        r_sel_ok;
  logic [7:0]  r_sel_val;
  logic        r_csw_ok;
  logic [1:0]  r_csw_size;
  logic        r_tar_ok;
  logic [31:0] r_tar_val;

  // Response result
  logic [31:0] r_rdata;
  logic        r_err;

  // A FLUSH in the accept cycle invalidates before the compare.
  logic        w_need_sel;
  logic        w_need_csw;
  logic        w_need_tar;
  logic [2:0]  w_stat;
  logic [31:0] w_rsp_data;

  assign w_need_sel = !(r_sel_ok && !FLUSH) || (AP_SEL   != r_sel_val);
  assign w_need_csw = !(r_csw_ok && !FLUSH) || (REQ_SIZE != r_csw_size);
  assign w_need_tar = !(r_tar_ok && !FLUSH) || (REQ_ADDR != r_tar_val);

  assign w_stat     = ADI_RDDATA[2:0];
  assign w_rsp_data = ADI_RDDATA[RSP_W-1:3];

  assign REQ_READY  = (r_state == ST_IDLE);
  assign RSP_VALID  = (r_state == ST_DONE);
  assign RSP_RDATA  = r_rdata;
  assign RSP_ERR    = r_err;

  // Command push: one cycle per command state, gated by FIFO space.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    CMD_WREN   = 1'b0;
    CMD_WRDATA = '0;
    case (r_state)
      ST_SEL:   CMD_WRDATA = {r_ap, 24'h0, DP_SELECT};
      ST_CSW:   CMD_WRDATA = {CSW_BASE[31:3], 1'b0, r_size, AP_CSW};
      ST_TAR:   CMD_WRDATA = {r_addr, AP_TAR};
      ST_DRW:   CMD_WRDATA = r_write ? {r_wdata, AP_DRW}
                                     : {32'h0, AP_DRW | 4'b0001};
      ST_RDBUF: CMD_WRDATA = {32'h0, DP_RDBUFF | 4'b0001};
      default:  CMD_WRDATA = '0;
    endcase
    CMD_WREN = (r_state inside {ST_SEL, ST_CSW, ST_TAR, ST_DRW, ST_RDBUF})
               && !CMD_WRFULL;
  end

  // Pop only in WAIT and only once per command, so never alongside a push.
  assign ADI_RDEN = (r_state == ST_WAIT) && !r_popped && !ADI_RDEMPTY;

  // NOTE: all state below is sequential and uses non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_cur        <= ST_IDLE;
      r_popped     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_write      <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ap         <= '0;
      r_need_sel   <= 1'b0;
      r_need_csw   <= 1'b0;
      r_need_tar   <= 1'b0;
      r_sel_ok     <= 1'b0;
      r_sel_val    <= '0;
      r_csw_ok     <= 1'b0;
      r_csw_size   <= 2'd0;
      r_tar_ok     <= 1'b0;
      r_tar_val    <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      // A FLUSH seen while busy is remembered until the request finishes.
      if (FLUSH && (r_state != ST_IDLE))
        r_flush_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (FLUSH) begin
            r_sel_ok <= 1'b0;
            r_csw_ok <= 1'b0;
            r_tar_ok <= 1'b0;
          end
          if (REQ_VALID) begin
            r_write    <= REQ_WRITE;
            r_size     <= REQ_SIZE;
            r_addr     <= REQ_ADDR;
            r_wdata    <= REQ_WDATA;
            r_ap       <= AP_SEL;
            r_need_sel <= w_need_sel;
            r_need_csw <= w_need_csw;
            r_need_tar <= w_need_tar;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_state    <= first_step(w_need_sel, w_need_csw, w_need_tar);
          end
        end

        ST_SEL, ST_CSW, ST_TAR, ST_DRW, ST_RDBUF: begin
          if (!CMD_WRFULL) begin
            r_cur    <= r_state;
            r_popped <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!r_popped) begin
            if (!ADI_RDEMPTY)
              r_popped <= 1'b1;
          end else begin
            r_popped <= 1'b0;
            if (w_stat == STAT_OK) begin
              case (r_cur)
                ST_SEL: begin
                  r_sel_ok   <= 1'b1;
                  r_sel_val  <= r_ap;
                  r_need_sel <= 1'b0;
                  r_state    <= first_step(1'b0, r_need_csw, r_need_tar);
                end
                ST_CSW: begin
                  r_csw_ok   <= 1'b1;
                  r_csw_size <= r_size;
                  r_need_csw <= 1'b0;
                  r_state    <= first_step(1'b0, 1'b0, r_need_tar);
                end
                ST_TAR: begin
                  r_tar_ok   <= 1'b1;
                  r_tar_val  <= r_addr;
                  r_need_tar <= 1'b0;
                  r_state    <= ST_DRW;
                end
                ST_DRW:
                  // AP reads are posted: the DRW response carries stale data.
                  r_state <= r_write ? ST_DONE : ST_RDBUF;
                ST_RDBUF: begin
                  r_rdata <= w_rsp_data;
                  r_state <= ST_DONE;
                end
                default: r_state <= ST_DONE;
              endcase
            end else begin
              // The target state is unknown after a fault: drop all caches.
              r_sel_ok <= 1'b0;
              r_csw_ok <= 1'b0;
              r_tar_ok <= 1'b0;
              r_err    <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (r_flush_pend || FLUSH) begin
            r_sel_ok <= 1'b0;
            r_csw_ok <= 1'b0;
            r_tar_ok <= 1'b0;
          end
          r_flush_pend <= 1'b0;
          r_state      <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adiv5_mem_ap_seq.sv
// ---------------------------------------------------------------------------
// tb_adiv5_mem_ap_seq
// Self-checking bench: a small swd_adiv5 model logs every pushed command and
// answers it after a fixed latency through a response queue whose data shows
// up the cycle after the pop. Directed vectors list the exact commands each
// request must produce; hand-written sequences cover FIFO-full stalls,
// FLUSH while busy and RESET while waiting.
// ---------------------------------------------------------------------------
module tb_adiv5_mem_ap_seq;
  import adiv5_pkg::*;

  localparam int LAT = 2;
  localparam logic [31:0] RDBUFF_VAL = 32'h1234_5678;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [7:0]        AP_SEL;
  logic              FLUSH;
  logic              REQ_VALID;
  logic              REQ_READY;
  logic              REQ_WRITE;
  logic [1:0]        REQ_SIZE;
  logic [31:0]       REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              RSP_VALID;
  logic [31:0]       RSP_RDATA;
  logic              RSP_ERR;
  logic [CMD_W-1:0]  CMD_WRDATA;
  logic              CMD_WREN;
  logic              CMD_WRFULL;
  logic [RSP_W-1:0]  ADI_RDDATA;
  logic              ADI_RDEN;
  logic              ADI_RDEMPTY;

  adiv5_mem_ap_seq #(.CSW_BASE(32'h2300_0000)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .AP_SEL     (AP_SEL),
    .FLUSH      (FLUSH),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_WRITE  (REQ_WRITE),
    .REQ_SIZE   (REQ_SIZE),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .CMD_WRDATA (CMD_WRDATA),
    .CMD_WREN   (CMD_WREN),
    .CMD_WRFULL (CMD_WRFULL),
    .ADI_RDDATA (ADI_RDDATA),
    .ADI_RDEN   (ADI_RDEN),
    .ADI_RDEMPTY(ADI_RDEMPTY)
  );

  always #5 CLK = ~CLK;

  // ---------------- swd_adiv5 model ----------------
  logic [CMD_W-1:0] cmd_log[$];
  logic [RSP_W-1:0] pend_q[$];
  int               pend_due[$];
  logic [RSP_W-1:0] rsp_q[$];
  int               cyc = 0;
  int               overlap = 0;
  int               fault_at = -1;   // absolute log index to answer with FAULT

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend_q.delete();
      pend_due.delete();
      rsp_q.delete();
      ADI_RDDATA  <= '0;
      ADI_RDEMPTY <= 1'b1;
    end else begin
      logic [31:0] d;
      logic [2:0]  st;
      cyc++;
      if (CMD_WREN && ADI_RDEN) overlap++;
      if (ADI_RDEN && rsp_q.size() > 0) ADI_RDDATA <= rsp_q.pop_front();
      if (CMD_WREN) begin
        d  = (CMD_WRDATA[3:0] == 4'b1101) ? RDBUFF_VAL : 32'h0;
        st = (cmd_log.size() == fault_at) ? STAT_FAULT : STAT_OK;
        cmd_log.push_back(CMD_WRDATA);
        pend_q.push_back({d, st});
        pend_due.push_back(cyc + LAT);
      end
      while (pend_q.size() > 0 && pend_due[0] <= cyc) begin
        rsp_q.push_back(pend_q.pop_front());
        void'(pend_due.pop_front());
      end
      ADI_RDEMPTY <= (rsp_q.size() == 0);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] cmd(input logic [31:0] d, input logic [3:0] n);
    return {d, n};
  endfunction

  task automatic start_req(input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!REQ_READY && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check("req_ready_timeout", {63'h0, REQ_READY}, 64'h1);
    REQ_VALID = 1'b1;
    REQ_WRITE = w;
    REQ_SIZE  = sz;
    REQ_ADDR  = a;
    REQ_WDATA = wd;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rdata, output logic err);
    logic got = 1'b0;
    rdata = '0;
    err   = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(posedge CLK); #1;
      if (RSP_VALID) begin
        got   = 1'b1;
        rdata = RSP_RDATA;
        err   = RSP_ERR;
      end
    end
    check("rsp_timeout", {63'h0, got}, 64'h1);
  endtask

  typedef struct {
    logic             w;
    logic [1:0]       size;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [7:0]       ap;
    int               fault_idx;  // -1 = none, else command index to fault
    int               ncmd;
    logic [4:0][35:0] cmds;
    logic             err;
    logic [31:0]      rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic run_checked(input string tag, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int ncmd, input logic [4:0][35:0] cmds,
                             input logic exp_err, input logic [31:0] exp_rd);
    int          base;
    logic [31:0] rd;
    logic        er;
    base = cmd_log.size();
    start_req(w, sz, a, wd);
    wait_rsp(rd, er);
    check({tag, "_ncmd"}, 64'(cmd_log.size() - base), 64'(ncmd));
    for (int i = 0; i < ncmd; i++)
      if (base + i < cmd_log.size())
        check($sformatf("%s_cmd%0d", tag, i), 64'(cmd_log[base + i]), 64'(cmds[i]));
    check({tag, "_err"}, {63'h0, er}, {63'h0, exp_err});
    check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
  endtask

  initial begin
    logic [4:0][35:0] c;
    int               base;
    int               hi;

    RESET = 1'b1; AP_SEL = 8'h00; FLUSH = 1'b0; REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0; REQ_SIZE = 2'd0; REQ_ADDR = '0; REQ_WDATA = '0;
    CMD_WRFULL = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", {63'h0, REQ_READY}, 64'h1);
    check("rst_rsp_valid", {63'h0, RSP_VALID}, 64'h0);
    check("rst_rsp_err",   {63'h0, RSP_ERR},   64'h0);
    check("rst_rsp_rdata", 64'(RSP_RDATA),     64'h0);
    check("rst_cmd_wren",  {63'h0, CMD_WREN},  64'h0);
    check("rst_adi_rden",  {63'h0, ADI_RDEN},  64'h0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Vectors are applied in order; each one's cache state follows from the
    // previous ones.
    for (int i = 0; i < 8; i++) begin
      vecs[i].cmds = '0; vecs[i].fault_idx = -1; vecs[i].err = 1'b0;
      vecs[i].rdata = 32'h0; vecs[i].ap = 8'h00;
    end
    // 0: cold word write
    vecs[0].w = 1; vecs[0].size = 2; vecs[0].addr = 32'h2000_0000;
    vecs[0].wdata = 32'hDEAD_BEEF; vecs[0].ncmd = 4;
    vecs[0].cmds[0] = cmd(32'h0000_0000, 4'b1000);
    vecs[0].cmds[1] = cmd(32'h2300_0002, 4'b0010);
    vecs[0].cmds[2] = cmd(32'h2000_0000, 4'b0110);
    vecs[0].cmds[3] = cmd(32'hDEAD_BEEF, 4'b1110);
    // 1: same write, fully cached
    vecs[1] = vecs[0]; vecs[1].ncmd = 1; vecs[1].cmds = '0;
    vecs[1].cmds[0] = cmd(32'hDEAD_BEEF, 4'b1110);
    // 2: warm word read
    vecs[2].w = 0; vecs[2].size = 2; vecs[2].addr = 32'h2000_0000;
    vecs[2].wdata = 32'hFFFF_FFFF; vecs[2].ncmd = 2; vecs[2].rdata = RDBUFF_VAL;
    vecs[2].cmds[0] = cmd(32'h0, 4'b1111);
    vecs[2].cmds[1] = cmd(32'h0, 4'b1101);
    // 3: byte write, same address: CSW only
    vecs[3].w = 1; vecs[3].size = 0; vecs[3].addr = 32'h2000_0000;
    vecs[3].wdata = 32'h0000_00AB; vecs[3].ncmd = 2;
    vecs[3].cmds[0] = cmd(32'h2300_0000, 4'b0010);
    vecs[3].cmds[1] = cmd(32'h0000_00AB, 4'b1110);
    // 4: AP_SEL change: SELECT only
    vecs[4] = vecs[3]; vecs[4].ap = 8'h01; vecs[4].cmds = '0;
    vecs[4].cmds[0] = cmd(32'h0100_0000, 4'b1000);
    vecs[4].cmds[1] = cmd(32'h0000_00AB, 4'b1110);
    // 5: half read, new address on AP 1
    vecs[5].w = 0; vecs[5].size = 1; vecs[5].addr = 32'h2000_0002;
    vecs[5].wdata = 32'h0; vecs[5].ap = 8'h01; vecs[5].ncmd = 4;
    vecs[5].rdata = RDBUFF_VAL;
    vecs[5].cmds[0] = cmd(32'h2300_0001, 4'b0010);
    vecs[5].cmds[1] = cmd(32'h2000_0002, 4'b0110);
    vecs[5].cmds[2] = cmd(32'h0, 4'b1111);
    vecs[5].cmds[3] = cmd(32'h0, 4'b1101);
    // 6: fault on the TAR write: no DRW
    vecs[6].w = 1; vecs[6].size = 2; vecs[6].addr = 32'h2000_0010;
    vecs[6].wdata = 32'h55AA_55AA; vecs[6].ncmd = 3; vecs[6].fault_idx = 2;
    vecs[6].err = 1'b1;
    vecs[6].cmds[0] = cmd(32'h0000_0000, 4'b1000);
    vecs[6].cmds[1] = cmd(32'h2300_0002, 4'b0010);
    vecs[6].cmds[2] = cmd(32'h2000_0010, 4'b0110);
    // 7: identical request after the fault is cold again
    vecs[7] = vecs[6]; vecs[7].fault_idx = -1; vecs[7].err = 1'b0; vecs[7].ncmd = 4;
    vecs[7].cmds[3] = cmd(32'h55AA_55AA, 4'b1110);

    for (int i = 0; i < 8; i++) begin
      AP_SEL   = vecs[i].ap;
      fault_at = (vecs[i].fault_idx < 0) ? -1 : cmd_log.size() + vecs[i].fault_idx;
      run_checked($sformatf("vec%0d", i), vecs[i].w, vecs[i].size, vecs[i].addr,
                  vecs[i].wdata, vecs[i].ncmd, vecs[i].cmds, vecs[i].err,
                  vecs[i].rdata);
    end
    fault_at = -1;

    // Command FIFO full for 20 cycles on a cached write.
    base = cmd_log.size();
    hi = 0;
    CMD_WRFULL = 1'b1;
    start_req(1'b1, 2'd2, 32'h2000_0010, 32'h0BAD_F00D);
    for (int i = 0; i < 20; i++) begin
      if (CMD_WREN) hi++;
      @(posedge CLK); #1;
    end
    check("full_no_wren", 64'(hi), 64'h0);
    CMD_WRFULL = 1'b0;
    #1;
    check("full_release_wren", {63'h0, CMD_WREN}, 64'h1);
    check("full_release_data", 64'(CMD_WRDATA), 64'(cmd(32'h0BAD_F00D, 4'b1110)));
    begin
      logic [31:0] rd; logic er;
      wait_rsp(rd, er);
      check("full_ncmd", 64'(cmd_log.size() - base), 64'h1);
      check("full_err", {63'h0, er}, 64'h0);
    end

    // FLUSH while a cached write is in flight: next request is cold.
    base = cmd_log.size();
    start_req(1'b1, 2'd2, 32'h2000_0010, 32'h1111_2222);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    begin
      logic [31:0] rd; logic er;
      wait_rsp(rd, er);
      check("flush_busy_ncmd", 64'(cmd_log.size() - base), 64'h1);
    end
    c = '0;
    c[0] = cmd(32'h0000_0000, 4'b1000);
    c[1] = cmd(32'h2300_0002, 4'b0010);
    c[2] = cmd(32'h2000_0010, 4'b0110);
    c[3] = cmd(32'h1111_2222, 4'b1110);
    run_checked("post_flush", 1'b1, 2'd2, 32'h2000_0010, 32'h1111_2222, 4, c,
                1'b0, 32'h0);

    // RESET while waiting for the DRW read response.
    base = cmd_log.size();
    start_req(1'b0, 2'd2, 32'h2000_0010, 32'h0);
    for (int i = 0; i < 50 && cmd_log.size() == base; i++) begin
      @(posedge CLK); #1;
    end
    check("rst_mid_pushed", 64'(cmd_log.size() - base), 64'h1);
    RESET = 1'b1;
    #1;
    check("rst_mid_req_ready", {63'h0, REQ_READY}, 64'h1);
    check("rst_mid_rsp_valid", {63'h0, RSP_VALID}, 64'h0);
    check("rst_mid_rsp_err",   {63'h0, RSP_ERR},   64'h0);
    check("rst_mid_rsp_rdata", 64'(RSP_RDATA),     64'h0);
    check("rst_mid_wren",      {63'h0, CMD_WREN},  64'h0);
    check("rst_mid_rden",      {63'h0, ADI_RDEN},  64'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    c = '0;
    c[0] = cmd(32'h0000_0000, 4'b1000);
    c[1] = cmd(32'h2300_0002, 4'b0010);
    c[2] = cmd(32'h2000_0010, 4'b0110);
    c[3] = cmd(32'h0, 4'b1111);
    c[4] = cmd(32'h0, 4'b1101);
    run_checked("post_reset", 1'b0, 2'd2, 32'h2000_0010, 32'h0, 5, c,
                1'b0, RDBUFF_VAL);

    check("wren_rden_overlap", 64'(overlap), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
